// File: rtl/instr_enc_if.sv
// instr_enc_if
// Bundles the request and delivery sides of the RV32I instruction encoder.
//   Request side : req_valid/req_ready handshake plus the instruction fields
//                  (req_type, rd, rs1, rs2, funct3, funct7, imm).
//   Delivery side: ins_valid/ins_ready handshake, ins_word, ins_err.
//   Statistics   : ins_cnt (words delivered), err_cnt (errors delivered).
// The slave modport is the encoder; the master modport is whoever feeds
// requests and consumes encoded words.
interface instr_enc_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_type;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_word;
  logic        ins_err;
  logic [15:0] ins_cnt;
  logic [7:0]  err_cnt;

  modport master (
    output req_valid, req_type, rd, rs1, rs2, funct3, funct7, imm, ins_ready,
    input  req_ready, ins_valid, ins_word, ins_err, ins_cnt, err_cnt
  );

  modport slave (
    input  req_valid, req_type, rd, rs1, rs2, funct3, funct7, imm, ins_ready,
    output req_ready, ins_valid, ins_word, ins_err, ins_cnt, err_cnt
  );
endinterface

// File: rtl/instr_enc.sv
// instr_enc
// Encodes RV32I instruction requests into 32-bit instruction words and
// buffers them in a two-entry FIFO for an independent consumer.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - instr_enc_if.slave: request handshake + fields, delivery
//           handshake + word/error flag, delivered-word and error counters
// An illegal request is still accepted, but it is replaced by a NOP
// (addi x0,x0,0) with ins_err set so the consumer sees it in order.
module instr_enc (
  input  logic          clk,
  input  logic          rst_n,
  instr_enc_if.slave    bus
);

  typedef enum logic [3:0] {
    T_R     = 4'd0,
    T_LOAD  = 4'd1,
    T_I     = 4'd2,
    T_JALR  = 4'd3,
    T_S     = 4'd4,
    T_SB    = 4'd5,
    T_LUI   = 4'd6,
    T_AUIPC = 4'd7,
    T_UJ    = 4'd8,
    T_CSR   = 4'd9
  } reqType_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifoState_e;

  localparam logic [6:0]  OP_R     = 7'h33;
  localparam logic [6:0]  OP_LOAD  = 7'h03;
  localparam logic [6:0]  OP_I     = 7'h13;
  localparam logic [6:0]  OP_JALR  = 7'h67;
  localparam logic [6:0]  OP_S     = 7'h23;
  localparam logic [6:0]  OP_SB    = 7'h63;
  localparam logic [6:0]  OP_LUI   = 7'h37;
  localparam logic [6:0]  OP_AUIPC = 7'h17;
  localparam logic [6:0]  OP_UJ    = 7'h6F;
  localparam logic [6:0]  OP_CSR   = 7'h73;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  fifoState_e  r_state;
  logic        r_run;
  logic        r_insValid;
  logic [31:0] r_headWord;
  logic        r_headErr;
  logic [31:0] r_tailWord;
  logic        r_tailErr;
  logic [15:0] r_insCnt;
  logic [7:0]  r_errCnt;

  logic [31:0] w_imm;
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic [31:0] w_enc;
  logic        w_err;
  logic [31:0] w_word;
  logic        w_reqReady;
  logic        w_push;
  logic        w_pop;

  assign w_imm = bus.imm;

  // An immediate fits a signed N-bit field when every bit from N-1 upward
  // is a copy of the sign bit.
  assign w_fits12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_fits13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
  assign w_fits21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

  // Field packing and legality check for the current request.
  always_comb begin
    w_enc = NOP_WORD;
    w_err = 1'b0;
    case (bus.req_type)
      T_R: begin
        w_enc = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
        w_err = !((bus.funct7 == 7'h00) || (bus.funct7 == 7'h20));
      end
      T_LOAD: begin
        w_enc = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_LOAD};
        w_err = !w_fits12;
      end
      T_I: begin
        w_enc = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_I};
        // Shift-immediates carry their funct7 in imm[11:5].
        w_err = !w_fits12
              || ((bus.funct3 == 3'd1) && (w_imm[11:5] != 7'h00))
              || ((bus.funct3 == 3'd5) && (w_imm[11:5] != 7'h00)
                                       && (w_imm[11:5] != 7'h20));
      end
      T_JALR: begin
        w_enc = {w_imm[11:0], bus.rs1, 3'b000, bus.rd, OP_JALR};
        w_err = !w_fits12;
      end
      T_S: begin
        w_enc = {w_imm[11:5], bus.rs2, bus.rs1, bus.funct3, w_imm[4:0], OP_S};
        w_err = !w_fits12;
      end
      T_SB: begin
        w_enc = {w_imm[12], w_imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                 w_imm[4:1], w_imm[11], OP_SB};
        w_err = !w_fits13 || w_imm[0];
      end
      T_LUI: begin
        w_enc = {w_imm[31:12], bus.rd, OP_LUI};
        w_err = (w_imm[11:0] != 12'h000);
      end
      T_AUIPC: begin
        w_enc = {w_imm[31:12], bus.rd, OP_AUIPC};
        w_err = (w_imm[11:0] != 12'h000);
      end
      T_UJ: begin
        w_enc = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd, OP_UJ};
        w_err = !w_fits21 || w_imm[0];
      end
      T_CSR: begin
        w_enc = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_CSR};
        w_err = 1'b0;
      end
      default: begin
        w_enc = NOP_WORD;
        w_err = 1'b1;
      end
    endcase
  end

  assign w_word = w_err ? NOP_WORD : w_enc;

  // r_run keeps req_ready low until the first edge after reset release,
  // while still deriving ready purely from registered state.
  assign w_reqReady = r_run && (r_state != FULL);
  assign w_push     = bus.req_valid && w_reqReady;
  assign w_pop      = r_insValid && bus.ins_ready;

  // FIFO control: the head register drives the outputs directly, the tail
  // register holds the second word only while FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_run      <= 1'b0;
      r_insValid <= 1'b0;
      r_headWord <= 32'h0;
      r_headErr  <= 1'b0;
      r_tailWord <= 32'h0;
      r_tailErr  <= 1'b0;
      r_insCnt   <= 16'h0;
      r_errCnt   <= 8'h0;
    end else begin
      r_run <= 1'b1;
      if (w_pop) begin
        r_insCnt <= r_insCnt + 16'd1;
        if (r_headErr && (r_errCnt != 8'hFF)) begin
          r_errCnt <= r_errCnt + 8'd1;
        end
      end
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_headWord <= w_word;
            r_headErr  <= w_err;
            r_insValid <= 1'b1;
            r_state    <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_headWord <= w_word;
            r_headErr  <= w_err;
          end else if (w_push) begin
            r_tailWord <= w_word;
            r_tailErr  <= w_err;
            r_state    <= FULL;
          end else if (w_pop) begin
            r_insValid <= 1'b0;
            r_state    <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_headWord <= r_tailWord;
            r_headErr  <= r_tailErr;
            r_state    <= ONE;
          end
        end
        default: begin
          r_insValid <= 1'b0;
          r_state    <= EMPTY;
        end
      endcase
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.ins_valid = r_insValid;
  assign bus.ins_word  = r_headWord;
  assign bus.ins_err   = r_headErr;
  assign bus.ins_cnt   = r_insCnt;
  assign bus.err_cnt   = r_errCnt;

endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc
// Directed bench for instr_enc: reset values, encodings of every format,
// error substitution, FIFO fill/drain ordering, mid-operation reset, and
// counter wrap/saturation. Inputs change on the falling edge and outputs
// are observed on the falling edge, away from the active rising edge.
module tb_instr_enc;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] expIns;
  logic [7:0]  expErr;

  instr_enc_if ifc ();

  instr_enc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and counts and reports it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] t, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm);
    ifc.req_type = t;
    ifc.rd       = rd;
    ifc.rs1      = rs1;
    ifc.rs2      = rs2;
    ifc.funct3   = f3;
    ifc.funct7   = f7;
    ifc.imm      = imm;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single request, presented one cycle, consumer held off.
  task automatic pushOne(input string tag);
    checkOutput({tag, "_req_ready"}, {31'b0, ifc.req_ready}, 32'd1);
    ifc.req_valid = 1'b1;
    cycle();
    ifc.req_valid = 1'b0;
  endtask

  // Single pop; the expected counters follow the delivered error flag.
  task automatic popOne(input logic isErr);
    ifc.ins_ready = 1'b1;
    cycle();
    ifc.ins_ready = 1'b0;
    expIns = expIns + 16'd1;
    if (isErr && expErr != 8'hFF) expErr = expErr + 8'd1;
  endtask

  task automatic encodeCase(input string tag, input logic [3:0] t,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] expWord, input logic expE);
    applyStimulus(t, rd, rs1, rs2, f3, f7, imm);
    pushOne(tag);
    checkOutput({tag, "_valid"}, {31'b0, ifc.ins_valid}, 32'd1);
    checkOutput({tag, "_word"}, ifc.ins_word, expWord);
    checkOutput({tag, "_err"}, {31'b0, ifc.ins_err}, {31'b0, expE});
    popOne(expE);
    checkOutput({tag, "_ins_cnt"}, {16'b0, ifc.ins_cnt}, {16'b0, expIns});
    checkOutput({tag, "_err_cnt"}, {24'b0, ifc.err_cnt}, {24'b0, expErr});
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    checks = 0;
    failures = 0;
    expIns = 16'h0;
    expErr = 8'h0;
    ifc.req_valid = 1'b0;
    ifc.ins_ready = 1'b0;
    applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

    // Reset values while rst_n is low.
    #1;
    checkOutput("rst_ins_valid", {31'b0, ifc.ins_valid}, 32'd0);
    checkOutput("rst_req_ready", {31'b0, ifc.req_ready}, 32'd0);
    checkOutput("rst_ins_word", ifc.ins_word, 32'd0);
    checkOutput("rst_ins_err", {31'b0, ifc.ins_err}, 32'd0);
    checkOutput("rst_ins_cnt", {16'b0, ifc.ins_cnt}, 32'd0);
    checkOutput("rst_err_cnt", {24'b0, ifc.err_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_ready_before_edge", {31'b0, ifc.req_ready}, 32'd0);
    cycle();
    checkOutput("release_ready_after_edge", {31'b0, ifc.req_ready}, 32'd1);

    // Encodings of each format, plus illegal requests replaced by NOP.
    encodeCase("addi",   4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h0050_0093, 1'b0);
    encodeCase("beq",    4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0);
    encodeCase("lui",    4'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    encodeCase("sb_odd", 4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,        32'h0000_0013, 1'b1);
    encodeCase("jal",    4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        32'h0080_00EF, 1'b0);
    encodeCase("csrrw",  4'd9, 5'd0, 5'd5, 5'd0, 3'd1, 7'd0, 32'h0000_0300, 32'h3002_9073, 1'b0);
    encodeCase("jalr",   4'd3, 5'd0, 5'd1, 5'd0, 3'd7, 7'd0, 32'd0,        32'h0000_8067, 1'b0);
    encodeCase("srai",   4'd2, 5'd1, 5'd2, 5'd0, 3'd5, 7'd0, 32'h0000_0405, 32'h4051_5093, 1'b0);
    encodeCase("slli_bad", 4'd2, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'h0000_0405, 32'h0000_0013, 1'b1);
    encodeCase("add_sub", 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,      32'h4020_81B3, 1'b0);
    encodeCase("r_bad_f7", 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 32'd0,     32'h0000_0013, 1'b1);
    encodeCase("imm_max", 4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,    32'h7FF0_0093, 1'b0);
    encodeCase("imm_over", 4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,   32'h0000_0013, 1'b1);
    encodeCase("sw",     4'd4, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0);
    encodeCase("auipc_bad", 4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h0000_0013, 1'b1);
    encodeCase("type12", 4'd12, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,       32'h0000_0013, 1'b1);

    // Three back-to-back requests with the consumer stalled.
    applyStimulus(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    ifc.req_valid = 1'b1;
    checkOutput("bb_ready_a", {31'b0, ifc.req_ready}, 32'd1);
    cycle();
    checkOutput("bb_word_a", ifc.ins_word, 32'h0010_0093);
    applyStimulus(4'd2, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    checkOutput("bb_ready_b", {31'b0, ifc.req_ready}, 32'd1);
    cycle();
    checkOutput("bb_ready_full", {31'b0, ifc.req_ready}, 32'd0);
    applyStimulus(4'd2, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    cycle();
    checkOutput("bb_ready_still_full", {31'b0, ifc.req_ready}, 32'd0);
    checkOutput("bb_word_a_held", ifc.ins_word, 32'h0010_0093);
    ifc.ins_ready = 1'b1;
    cycle();
    checkOutput("bb_word_b", ifc.ins_word, 32'h0020_0113);
    checkOutput("bb_ready_after_pop", {31'b0, ifc.req_ready}, 32'd1);
    cycle();
    ifc.req_valid = 1'b0;
    checkOutput("bb_word_c", ifc.ins_word, 32'h0030_0193);
    checkOutput("bb_valid_c", {31'b0, ifc.ins_valid}, 32'd1);
    cycle();
    ifc.ins_ready = 1'b0;
    expIns = expIns + 16'd3;
    checkOutput("bb_empty", {31'b0, ifc.ins_valid}, 32'd0);
    checkOutput("bb_ins_cnt", {16'b0, ifc.ins_cnt}, {16'b0, expIns});

    // Fill the FIFO, then reset in the middle of a cycle.
    applyStimulus(4'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    ifc.req_valid = 1'b1;
    cycle();
    cycle();
    ifc.req_valid = 1'b0;
    checkOutput("pre_rst_full", {31'b0, ifc.req_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'b0, ifc.ins_valid}, 32'd0);
    checkOutput("midrst_ins_cnt", {16'b0, ifc.ins_cnt}, 32'd0);
    checkOutput("midrst_err_cnt", {24'b0, ifc.err_cnt}, 32'd0);
    checkOutput("midrst_ready", {31'b0, ifc.req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ifc.ins_ready = 1'b1;
    repeat (3) cycle();
    checkOutput("post_rst_no_stale", {31'b0, ifc.ins_valid}, 32'd0);
    checkOutput("post_rst_ins_cnt", {16'b0, ifc.ins_cnt}, 32'd0);
    expIns = 16'h0;
    expErr = 8'h0;

    // Stream illegal requests: err_cnt saturates, ins_cnt wraps after 65536.
    applyStimulus(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    ifc.req_valid = 1'b1;
    cycle();
    for (int i = 1; i <= 65535; i++) begin
      cycle();
      if (i == 1) begin
        checkOutput("stream_word", ifc.ins_word, 32'h0000_0013);
        checkOutput("stream_err", {31'b0, ifc.ins_err}, 32'd1);
      end
      if (i == 254) checkOutput("err_cnt_254", {24'b0, ifc.err_cnt}, 32'hFE);
      if (i == 255) checkOutput("err_cnt_255", {24'b0, ifc.err_cnt}, 32'hFF);
      if (i == 300) begin
        checkOutput("err_cnt_sat", {24'b0, ifc.err_cnt}, 32'hFF);
        checkOutput("ins_cnt_300", {16'b0, ifc.ins_cnt}, 32'd300);
      end
      if (i == 65535) checkOutput("ins_cnt_max", {16'b0, ifc.ins_cnt}, 32'hFFFF);
    end
    ifc.req_valid = 1'b0;
    cycle();
    checkOutput("ins_cnt_wrap", {16'b0, ifc.ins_cnt}, 32'd0);
    checkOutput("err_cnt_hold", {24'b0, ifc.err_cnt}, 32'hFF);
    checkOutput("stream_drained", {31'b0, ifc.ins_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
